// File: rtl/cla_16bit.sv
// rtl/cla_16bit.sv - registered 16-bit carry-lookahead propagate/generate unit
// Per-bit OR-propagate/AND-generate plus nibble group terms, all captured in one flop stage.
module cla_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] P,
    output logic [15:0] G,
    output logic        P03,
    output logic        P47,
    output logic        P811,
    output logic        P1215,
    output logic        G03,
    output logic        G47,
    output logic        G811,
    output logic        G1215
);

    logic [15:0] w_p;
    logic [15:0] w_g;
    logic [3:0]  w_pgrp;
    logic [3:0]  w_ggrp;

    logic [15:0] r_p;
    logic [15:0] r_g;
    logic [3:0]  r_pgrp;
    logic [3:0]  r_ggrp;

    assign w_p = A | B;
    assign w_g = A & B;

    // Group terms come from the live per-bit terms so every output describes the same operand pair.
    always_comb begin
        w_pgrp = '0;
        w_ggrp = '0;
        for (int k = 0; k < 4; k++) begin
            w_pgrp[k] = w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k];
            w_ggrp[k] = w_g[4*k+3]
                      | (w_p[4*k+3] & w_g[4*k+2])
                      | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                      | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p    <= '0;
            r_g    <= '0;
            r_pgrp <= '0;
            r_ggrp <= '0;
        end else begin
            r_p    <= w_p;
            r_g    <= w_g;
            r_pgrp <= w_pgrp;
            r_ggrp <= w_ggrp;
        end
    end

    assign P     = r_p;
    assign G     = r_g;
    assign P03   = r_pgrp[0];
    assign P47   = r_pgrp[1];
    assign P811  = r_pgrp[2];
    assign P1215 = r_pgrp[3];
    assign G03   = r_ggrp[0];
    assign G47   = r_ggrp[1];
    assign G811  = r_ggrp[2];
    assign G1215 = r_ggrp[3];

endmodule

// File: tb/tb_cla_16bit.sv
// tb/tb_cla_16bit.sv - self-checking bench for cla_16bit
module tb_cla_16bit;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] P;
    logic [15:0] G;
    logic        P03, P47, P811, P1215;
    logic        G03, G47, G811, G1215;

    int n_assert;
    int n_fail;

    cla_16bit dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .P     (P),
        .G     (G),
        .P03   (P03),
        .P47   (P47),
        .P811  (P811),
        .P1215 (P1215),
        .G03   (G03),
        .G47   (G47),
        .G811  (G811),
        .G1215 (G1215)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed as {P, G, group P [3:0], group G [3:0]}.
    function automatic logic [39:0] observed();
        return {P, G, P1215, P811, P47, P03, G1215, G811, G47, G03};
    endfunction

    // Group generate is the carry out of a 4-bit add with no carry in; group propagate is all bits OR-true.
    function automatic logic [39:0] model(logic [15:0] a, logic [15:0] b);
        logic [3:0]  pg;
        logic [3:0]  gg;
        logic [15:0] orab;
        orab = a | b;
        for (int k = 0; k < 4; k++) begin
            pg[k] = (orab[4*k +: 4] == 4'hF);
            gg[k] = ((int'(a[4*k +: 4]) + int'(b[4*k +: 4])) >= 16);
        end
        return {orab, a & b, pg, gg};
    endfunction

    // Consumer-side sum: group carries chain the nibbles, ripple within each nibble.
    function automatic logic [16:0] sum_from(logic [39:0] v);
        logic [15:0] p, g, s;
        logic [3:0]  pg, gg;
        logic        cgrp, c;
        {p, g, pg, gg} = v;
        cgrp = 1'b0;
        s    = '0;
        for (int k = 0; k < 4; k++) begin
            c = cgrp;
            for (int j = 0; j < 4; j++) begin
                s[4*k+j] = (p[4*k+j] & ~g[4*k+j]) ^ c;
                c        = g[4*k+j] | (p[4*k+j] & c);
            end
            cgrp = gg[k] | (pg[k] & cgrp);
        end
        return {cgrp, s};
    endfunction

    task automatic chk(string tag, logic [39:0] obs, logic [39:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one operand pair, let one edge capture it, then check outputs and the derived sum.
    task automatic step(string tag, logic [15:0] a, logic [15:0] b, logic chk_sum);
        logic [16:0] want;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        chk(tag, observed(), model(a, b));
        if (chk_sum) begin
            want = {1'b0, a} + {1'b0, b};
            chk({tag, "_sum"}, {23'd0, sum_from(observed())}, {23'd0, want});
        end
    endtask

    initial begin
        logic [15:0] ra, rb;
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        A   = 16'hFFFF;
        B   = 16'hFFFF;

        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("reset_hold", observed(), 40'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_release", observed(), {16'hFFFF, 16'hFFFF, 4'hF, 4'hF});

        step("ffff_0001", 16'hFFFF, 16'h0001, 1'b1);
        chk("ffff_0001_lit", observed(), {16'hFFFF, 16'h0001, 4'hF, 4'b0001});
        chk("ffff_0001_sum_lit", {23'd0, sum_from(observed())}, {23'd0, 17'h10000});
        step("f0f0_0f0f", 16'hF0F0, 16'h0F0F, 1'b1);
        chk("f0f0_0f0f_lit", observed(), {16'hFFFF, 16'h0000, 4'hF, 4'h0});
        step("8888_8888", 16'h8888, 16'h8888, 1'b1);
        chk("8888_8888_lit", observed(), {16'h8888, 16'h8888, 4'h0, 4'hF});
        chk("8888_sum_lit", {23'd0, sum_from(observed())}, {23'd0, 17'h11110});
        step("1234_0000", 16'h1234, 16'h0000, 1'b1);
        chk("1234_0000_lit", observed(), {16'h1234, 16'h0000, 4'h0, 4'h0});

        // Reset mid-stream discards the operand pair present at that edge.
        A   = 16'hABCD;
        B   = 16'h1357;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_reset", observed(), 40'd0);
        rst = 1'b0;
        step("after_reset", 16'h00FF, 16'h0F0F, 1'b1);

        for (int i = 0; i < 220; i++)
            step("stream", 16'hFFFF, 16'(i), 1'b1);

        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            step("random", ra, rb, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
